// File: rtl/mcc_pkg.sv
// Shared types for the multi-cycle control sequencer: state encoding, opcodes, trap causes.
// Pure declarations; no timing or flow-control behaviour of its own.
package mcc_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] TC_NONE      = 2'b00;
    localparam logic [1:0] TC_ILLEGAL   = 2'b01;
    localparam logic [1:0] TC_FETCH_TMO = 2'b10;
    localparam logic [1:0] TC_DATA_TMO  = 2'b11;

    function automatic logic op_legal(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I)  || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/mcc_mem_timeout.sv
// Memory-wait watchdog: counts stalled cycles; expired_o is combinational and fires on the
// (2**TMO_W-1)th consecutive enabled cycle. clr_i has priority over en_i; no backpressure.
module mcc_mem_timeout #(
    parameter int TMO_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    // Counter holds the number of prior wait cycles, so the terminal wait sees 2**TMO_W-2.
    localparam logic [TMO_W-1:0] CNT_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer; stalls on mem_ready, traps on illegal op/timeout.
// MCC_PERF_CNT_EN adds cyc_cnt/instret performance counters.
module multicycle_ctrl_fsm
    import mcc_pkg::*;
#(
    parameter int OP_W  = 7,
    parameter int TMO_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic [OP_W-1:0] op,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic            ir_we,
    output logic            pc_we,
    output logic            pc_sel,
    output logic            rf_we,
    output logic [2:0]      phase,
    output logic            trap,
    output logic [1:0]      trap_cause
`ifdef MCC_PERF_CNT_EN
    ,
    output logic [31:0]     cyc_cnt,
    output logic [31:0]     instret
`endif
);

    state_t          state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [1:0]      cause_q, cause_d;
    logic            tmo_clr;
    logic            tmo_en;
    logic            tmo_exp;
    state_t          retire_st;

    assign tmo_en    = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
    assign tmo_clr   = (state_d != state_q);
    assign retire_st = run ? S_FETCH : S_IDLE;

    mcc_mem_timeout #(.TMO_W(TMO_W)) u_tmo (
        .clk       (clk),
        .rst_n     (rst),
        .clr_i     (tmo_clr),
        .en_i      (tmo_en),
        .expired_o (tmo_exp)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cause_d = cause_q;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        pc_sel  = 1'b0;
        rf_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (tmo_exp) begin
                    state_d = S_TRAP;
                    cause_d = TC_FETCH_TMO;
                end
            end
            S_DECODE: begin
                // The opcode is captured here so later IR changes cannot redirect the instruction.
                op_d = op;
                if (op_legal(op)) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    cause_d = TC_ILLEGAL;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_BEQ: begin
                        pc_sel  = 1'b1;
                        pc_we   = zero;
                        state_d = retire_st;
                    end
                    OP_LW, OP_SW: state_d = S_MEM;
                    default:      state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (op_q == OP_SW);
                if (mem_ready) begin
                    state_d = (op_q == OP_LW) ? S_WB : retire_st;
                end else if (tmo_exp) begin
                    state_d = S_TRAP;
                    cause_d = TC_DATA_TMO;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                state_d = retire_st;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cause_q <= TC_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cause_q <= cause_d;
        end
    end

    assign phase      = state_q;
    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;

`ifdef MCC_PERF_CNT_EN
    logic [31:0] cyc_q;
    logic [31:0] ret_q;
    logic        retire;

    assign retire = (state_q == S_WB) ||
                    ((state_q == S_EXEC) && (op_q == OP_BEQ)) ||
                    ((state_q == S_MEM) && mem_ready && (op_q == OP_SW));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            if ((state_q != S_IDLE) && (state_q != S_TRAP)) begin
                cyc_q <= cyc_q + 32'd1;
            end
            if (retire) begin
                ret_q <= ret_q + 32'd1;
            end
        end
    end

    assign cyc_cnt = cyc_q;
    assign instret = ret_q;
`endif

endmodule
